// File: rtl/sae_stream.sv
// -----------------------------------------------------------------------------
// sae_stream: streaming SAE engine.
//   One character per cycle enters through a valid/ready handshake, passes a
//   single registered compute stage and lands in a show-ahead output FIFO that
//   is drained by output_ack. Key generation stores the private key internally;
//   decryption always uses the stored key.
//
// Optional feature: define SAE_STATS_EN to add the char_count/err_count
// saturating statistics outputs.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mode                    00 idle (dropped), 01 keygen, 10 encrypt, 11 decrypt
//   data_input              plaintext/ciphertext character
//   key_input               private key (keygen) or peer public key (encrypt)
//   inputs_valid/_ready     input handshake
//   data_output             FIFO head data (0 while empty)
//   output_ready/output_ack FIFO head valid / consume head
//   err_invalid_*           FIFO head error flags
//   char_count, err_count   pushed entries / pushed entries with errors
//                           (SAE_STATS_EN only)
//   key_loaded              a valid private key is stored
// -----------------------------------------------------------------------------
module sae_stream #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MODULUS = 251,
  parameter int unsigned DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_input,
  input  logic [DATA_W-1:0] key_input,
  input  logic              inputs_valid,
  output logic              inputs_ready,
  output logic [DATA_W-1:0] data_output,
  output logic              output_ready,
  input  logic              output_ack,
  output logic              err_invalid_ptxt_char,
  output logic              err_invalid_seckey,
  output logic              err_invalid_ctxt_char,
`ifdef SAE_STATS_EN
  output logic [15:0]       char_count,
  output logic [15:0]       err_count,
`endif
  output logic              key_loaded
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_W:0] MOD_W = (DATA_W + 1)'(MODULUS);

  typedef struct packed {
    logic              ptxt;
    logic              seckey;
    logic              ctxt;
    logic [DATA_W-1:0] data;
  } entry_t;

  // (a + b) mod M for operands already below M
  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= MOD_W) sum = sum - MOD_W;
    return DATA_W'(sum);
  endfunction

  logic [DATA_W-1:0] sk;
  logic              stage_valid;
  entry_t            stage;
  entry_t            res;
  logic              key_in_ok;
  logic              data_ok;
  logic              accept;
  logic              compute;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              push;
  logic              pop;
  entry_t            head;

  // Slot reservation: the stage entry always has a FIFO slot waiting for it
  assign occupancy    = {1'b0, count} + (CNT_W + 1)'(stage_valid);
  assign inputs_ready = rst_n && (occupancy < (CNT_W + 1)'(DEPTH));
  assign accept       = inputs_valid && inputs_ready;
  assign compute      = accept && (mode != 2'b00);

  // Per-beat result and error flags
  always_comb begin
    res       = '0;
    key_in_ok = (key_input != '0) && ({1'b0, key_input} < MOD_W);
    data_ok   = ({1'b0, data_input} < MOD_W);
    case (mode)
      2'b01: begin
        if (key_in_ok) res.data = DATA_W'(MOD_W - {1'b0, key_input});
        else           res.seckey = 1'b1;
      end
      2'b10: begin
        res.seckey = !key_in_ok;
        res.ptxt   = !data_ok;
        if (key_in_ok && data_ok) res.data = add_mod(data_input, key_input);
      end
      2'b11: begin
        res.seckey = !key_loaded;
        res.ctxt   = !data_ok;
        if (key_loaded && data_ok) res.data = add_mod(data_input, sk);
      end
      default: ;
    endcase
  end

  // Compute stage and key register; a keygen beat is visible to the next beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage       <= '0;
      sk          <= '0;
      key_loaded  <= 1'b0;
    end else begin
      stage_valid <= compute;
      if (compute) stage <= res;
      if (compute && (mode == 2'b01) && key_in_ok) begin
        sk         <= key_input;
        key_loaded <= 1'b1;
      end
    end
  end

  assign push         = stage_valid;
  assign output_ready = (count != '0);
  assign pop          = output_ready && output_ack;

  // FIFO storage; contents are don't-care while not counted
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stage;
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero while empty so stale storage never shows
  assign head                  = mem[rd_ptr];
  assign data_output           = output_ready ? head.data   : '0;
  assign err_invalid_ptxt_char = output_ready ? head.ptxt   : 1'b0;
  assign err_invalid_seckey    = output_ready ? head.seckey : 1'b0;
  assign err_invalid_ctxt_char = output_ready ? head.ctxt   : 1'b0;

`ifdef SAE_STATS_EN
  // Saturating counters of pushed entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_count <= '0;
      err_count  <= '0;
    end else if (push) begin
      if (char_count != 16'hFFFF) char_count <= char_count + 16'd1;
      if ((stage.ptxt || stage.seckey || stage.ctxt) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sae_stream.md
Name: sae_stream

Overview:
- Streaming successor of the single-character SAE engine.
- Parametrised data width, modulus and output buffer depth.
- Stores the private key internally after key generation; decryption uses the stored key.
- Accepts one character per cycle with a valid/ready handshake and buffers results in a show-ahead output FIFO drained by an acknowledge.

Parameters:
DATA_W, 8, character/key width in bits
MODULUS, 251, arithmetic modulus M; 2 <= M <= 2**DATA_W
DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  per-beat operation: 00 idle, 01 keygen, 10 encrypt, 11 decrypt
data_input  in  DATA_W  plaintext/ciphertext character
key_input  in  DATA_W  private key (mode 01) or peer public key (mode 10); ignored in 00/11
inputs_valid  in  1  beat offered
inputs_ready  out  1  beat can be accepted
data_output  out  DATA_W  FIFO head data
output_ready  out  1  FIFO head valid
output_ack  in  1  consume FIFO head
err_invalid_ptxt_char  out  1  head flag
err_invalid_seckey  out  1  head flag (any invalid or missing key)
err_invalid_ctxt_char  out  1  head flag
key_loaded  out  1  a valid private key is stored

Behaviour:
- Reset (async, immediate): FIFO emptied, pipeline stage cleared, key register 0, key_loaded 0. All outputs 0 except inputs_ready, which is 1 once reset is released.
- Accept: a beat is accepted on a rising edge with inputs_valid && inputs_ready.
- inputs_ready = (fifo_count + stage_valid) < DEPTH, so an accepted beat always has a FIFO slot.
- Pipeline: a single compute stage registers the result at the accept edge and pushes it into the FIFO on the next edge. Into an empty FIFO, output_ready rises 2 edges after acceptance.
- Throughput: 1 beat/cycle while acked.
- Mode 00 beats are accepted and dropped; no FIFO entry is created.
- Arithmetic: add as a DATA_W+1 bit sum; if sum >= M, subtract M.
- Mode 01 (keygen):
  - Valid iff 1 <= key_input <= M-1.
  - Valid: store sk = key_input, set key_loaded, push pk = M - sk.
  - Invalid: push data 0 with err_invalid_seckey; key register and key_loaded unchanged.
- Mode 10 (encrypt):
  - Error if key_input = 0 or key_input >= M (seckey error).
  - Error if data_input >= M (ptxt error).
  - Otherwise push (data_input + key_input) mod M.
- Mode 11 (decrypt):
  - Error if !key_loaded (seckey error).
  - Error if data_input >= M (ctxt error).
  - Otherwise push (data_input + sk) mod M.
- Any error: data field 0. Multiple flags may be set in the same entry.
- A keygen beat updates sk at its accept edge; a decrypt beat accepted on the next cycle uses the new key.
- FIFO:
  - Show-ahead: head data and flags are held stable while output_ready=1 and output_ack=0.
  - Pop occurs when output_ready && output_ack.
  - output_ack while empty is ignored.
  - Simultaneous push and pop keeps the count unchanged; pointers wrap modulo DEPTH.
- Mode may change on every beat; no mode-switch dead cycle.
- Reset mid-stream discards all in-flight and buffered results.

Optional Feature:
- Macro: SAE_STATS_EN.
- Defined: adds outputs char_count[15:0] and err_count[15:0].
  - char_count increments per pushed entry.
  - err_count increments per pushed entry with any flag set.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Keygen: M=251, key_input=100, mode 01 -> entry 151, no flags; key_loaded=1.
- Round trip: encrypt 'A'(65) with key_input=151 -> 216; decrypt 216 with stored sk=100 -> 65. Stream the full plaintext back-to-back and compare the results byte for byte.
- Errors:
  - keygen key 0 -> data 0, err_invalid_seckey; key_loaded unchanged.
  - encrypt data 252 -> err_invalid_ptxt_char.
  - decrypt before any keygen -> err_invalid_seckey.
  - decrypt data 251 -> err_invalid_ctxt_char.
- Backpressure: DEPTH=4, output_ack=0, 6 encrypt beats offered -> exactly 4 accepted, inputs_ready=0, head stable. Assert output_ack for 1 cycle -> one pop, one more beat accepted. Verify order is preserved.
- Reset: assert rst_n=0 with 3 entries buffered -> output_ready=0, key_loaded=0 immediately. After release, decrypt -> err_invalid_seckey.
- SAE_STATS_EN: 5 beats including 2 errors -> char_count=5, err_count=2. Mode 00 beats are not counted.
